// File: rtl/udma_filter_tx_datafetch.sv
// uDMA filter TX datafetch: linear / 2D address generator reading L2,
// buffering returned words in a credit-limited FIFO and framing them as a stream.
module udma_filter_tx_datafetch #(
    parameter int DATA_WIDTH     = 32,
    parameter int L2_AWIDTH_NOAL = 15,
    parameter int TRANS_SIZE     = 16,
    parameter int BUFFER_DEPTH   = 4
) (
    input  logic                      clk_i,
    input  logic                      resetn_i,
    output logic                      tx_ch_req_o,
    output logic [L2_AWIDTH_NOAL-1:0] tx_ch_addr_o,
    output logic [1:0]                tx_ch_datasize_o,
    input  logic                      tx_ch_gnt_i,
    input  logic                      tx_ch_valid_i,
    input  logic [DATA_WIDTH-1:0]     tx_ch_data_i,
    output logic                      tx_ch_ready_o,
    input  logic                      cmd_start_i,
    output logic                      cmd_done_o,
    input  logic [L2_AWIDTH_NOAL-1:0] cfg_start_addr_i,
    input  logic [1:0]                cfg_datasize_i,
    input  logic [1:0]                cfg_mode_i,
    input  logic [TRANS_SIZE-1:0]     cfg_len0_i,
    input  logic [TRANS_SIZE-1:0]     cfg_len1_i,
    input  logic [TRANS_SIZE-1:0]     cfg_len2_i,
    output logic [DATA_WIDTH-1:0]     stream_data_o,
    output logic                      stream_sof_o,
    output logic                      stream_eof_o,
    output logic                      stream_valid_o,
    input  logic                      stream_ready_i
);
    localparam int AW = L2_AWIDTH_NOAL;
    localparam int CW = $clog2(BUFFER_DEPTH + 1);
    localparam int PW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                state;
    logic [1:0]            mode;
    logic [AW-1:0]         base;
    logic [TRANS_SIZE-1:0] inner, outer;
    logic [CW-1:0]         credits, pending, count;
    logic                  first;
    logic [PW-1:0]         wptr, rptr;
    logic [DATA_WIDTH+1:0] mem [BUFFER_DEPTH];

    logic                  col, row, grant, pop, last, inner_end, wr;
    logic [AW-1:0]         inc, stride, next_base;
    logic [TRANS_SIZE-1:0] inner_len, outer_len;

    always_comb begin
        inc = '0;
        case (cfg_datasize_i)
            2'd0: inc = AW'(1);
            2'd1: inc = AW'(2);
            2'd2: inc = AW'(4);
            default: inc = '0;
        endcase
    end

    assign col       = (mode == 2'd2);
    assign row       = (mode == 2'd1);
    assign stride    = AW'(cfg_len2_i);
    assign inner_len = col ? cfg_len1_i : cfg_len0_i;
    assign outer_len = row ? cfg_len1_i : (col ? cfg_len0_i : '0);
    assign inner_end = (inner == inner_len);
    assign last      = inner_end && (outer == outer_len);
    assign next_base = base + (col ? inc : stride);

    assign tx_ch_req_o      = (state == FETCH) && (credits < CW'(BUFFER_DEPTH));
    assign tx_ch_datasize_o = cfg_datasize_i;
    assign tx_ch_ready_o    = 1'b1;
    assign grant            = tx_ch_req_o & tx_ch_gnt_i;
    assign wr               = tx_ch_valid_i;

    assign stream_valid_o = (count != '0);
    assign stream_data_o  = mem[rptr][DATA_WIDTH-1:0];
    assign stream_sof_o   = stream_valid_o & mem[rptr][DATA_WIDTH];
    assign stream_eof_o   = stream_valid_o & mem[rptr][DATA_WIDTH+1];
    assign pop            = stream_valid_o & stream_ready_i;
    assign cmd_done_o     = pop & stream_eof_o;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state        <= IDLE;
            mode         <= '0;
            base         <= '0;
            tx_ch_addr_o <= '0;
            inner        <= '0;
            outer        <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_start_i) begin
                    state        <= FETCH;
                    mode         <= cfg_mode_i;
                    base         <= cfg_start_addr_i;
                    tx_ch_addr_o <= cfg_start_addr_i;
                    inner        <= '0;
                    outer        <= '0;
                end
                FETCH: if (grant) begin
                    if (last) begin
                        state <= DRAIN;
                    end else if (inner_end) begin
                        inner        <= '0;
                        outer        <= outer + 1'b1;
                        base         <= next_base;
                        tx_ch_addr_o <= next_base;
                    end else begin
                        inner        <= inner + 1'b1;
                        tx_ch_addr_o <= tx_ch_addr_o + (col ? stride : inc);
                    end
                end
                DRAIN: if (cmd_done_o) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Credits cover both outstanding reads and words sitting in the FIFO.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            credits <= '0;
            pending <= '0;
            first   <= 1'b0;
        end else begin
            credits <= credits + CW'(grant) - CW'(pop);
            pending <= pending + CW'(grant) - CW'(wr);
            if (state == IDLE && cmd_start_i) first <= 1'b1;
            else if (wr)                       first <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                mem[wptr] <= {(state == DRAIN) && (pending == CW'(1)), first, tx_ch_data_i};
                wptr      <= (wptr == PW'(BUFFER_DEPTH - 1)) ? '0 : wptr + 1'b1;
            end
            if (pop) rptr <= (rptr == PW'(BUFFER_DEPTH - 1)) ? '0 : rptr + 1'b1;
            count <= count + CW'(wr) - CW'(pop);
        end
    end
endmodule

// File: doc/udma_filter_tx_datafetch.md
UDMA_FILTER_TX_DATAFETCH -- requirements
Module: udma_filter_tx_datafetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, L2 data and stream width.
REQ-002 SHALL have parameter L2_AWIDTH_NOAL, default 15, L2 word-address width.
REQ-003 SHALL have parameter TRANS_SIZE, default 16, length-counter width.
REQ-004 SHALL have parameter BUFFER_DEPTH, default 4, internal FIFO depth and maximum number of requests in flight.
REQ-005 SHALL have ports clk_i (in, 1, clock) and resetn_i (in, 1, reset); one clock; reset is asynchronous and active-low.
REQ-006 SHALL have L2 read ports tx_ch_req_o (out, 1), tx_ch_addr_o (out, L2_AWIDTH_NOAL), tx_ch_datasize_o (out, 2), tx_ch_gnt_i (in, 1), tx_ch_valid_i (in, 1), tx_ch_data_i (in, DATA_WIDTH), tx_ch_ready_o (out, 1).
REQ-007 SHALL have command ports cmd_start_i (in, 1, start pulse) and cmd_done_o (out, 1, one-cycle completion pulse).
REQ-008 SHALL have config inputs cfg_start_addr_i (L2_AWIDTH_NOAL), cfg_datasize_i (2), cfg_mode_i (2), cfg_len0_i, cfg_len1_i and cfg_len2_i (TRANS_SIZE each).
REQ-009 SHALL have stream outputs stream_data_o (DATA_WIDTH), stream_sof_o (1), stream_eof_o (1) and stream_valid_o (1), plus stream_ready_i (in, 1).

Function
REQ-010 SHALL implement states IDLE, FETCH and DRAIN.
REQ-011 SHALL leave IDLE for FETCH on cmd_start_i and latch mode, start address and row base address; cmd_start_i SHALL be ignored outside IDLE.
REQ-012 SHALL use address increment 1, 2 or 4 for datasize 0, 1 or 2, and 0 for datasize 3; tx_ch_datasize_o SHALL equal cfg_datasize_i.
REQ-013 SHALL, in mode 0 (linear), issue cfg_len0_i+1 requests at consecutive addresses.
REQ-014 SHALL, in mode 1 (2D row), issue cfg_len1_i+1 rows of cfg_len0_i+1 elements; each new row starts at previous row base + cfg_len2_i.
REQ-015 SHALL, in mode 2 (2D col), issue cfg_len0_i+1 columns of cfg_len1_i+1 elements with stride cfg_len2_i; each new column starts at previous column base + increment.
REQ-016 SHALL treat mode 3 as linear.
REQ-017 SHALL compute all address sums modulo 2^L2_AWIDTH_NOAL.
REQ-018 SHALL assert tx_ch_req_o in FETCH only while credits < BUFFER_DEPTH.
REQ-019 SHALL advance counters and tx_ch_addr_o only on tx_ch_req_o & tx_ch_gnt_i; address and request SHALL be held stable while ungranted.
REQ-020 SHALL increment the credit counter on grant and decrement it on stream pop (valid & ready); simultaneous grant and pop SHALL leave it unchanged.
REQ-021 SHALL move FETCH to DRAIN on the grant of the last request; no further requests SHALL be issued.
REQ-022 SHALL hold tx_ch_ready_o at 1; each tx_ch_valid_i beat SHALL be written to the FIFO in order (the credit limit guarantees space).
REQ-023 SHALL present the FIFO head on stream_data_o with stream_valid_o = FIFO not empty; data SHALL pass unmodified.
REQ-024 SHALL assert stream_sof_o with the first element of a command and stream_eof_o with the last, both qualified by stream_valid_o.
REQ-025 SHALL, when the last element (eof) pops, pulse cmd_done_o for one cycle in that same cycle and return to IDLE.
REQ-026 SHALL produce a single element with both sof and eof for len0 = len1 = 0.
REQ-027 SHALL fix request-to-stream latency at one cycle after tx_ch_valid_i (FIFO write then read).

Reset
REQ-028 SHALL, on resetn_i low, asynchronously clear state to IDLE, credits, counters, addresses and the FIFO.
REQ-029 SHALL drive tx_ch_req_o, stream_valid_o, stream_sof_o, stream_eof_o and cmd_done_o to 0 and tx_ch_addr_o to 0 while in reset.
REQ-030 SHALL, on reset mid-command, discard in-flight data; the first command after reset SHALL behave as from power-up.

Verification
REQ-031 SHALL cover: linear, start 0x100, datasize 2, len0 3, gnt always 1, data returned next cycle -> addresses 0x100, 0x104, 0x108, 0x10C; 4 stream beats; sof on beat 0, eof on beat 3; cmd_done_o with beat 3.
REQ-032 SHALL cover: 2D row, start 0x40, datasize 0, len0 1, len1 1, len2 0x10 -> addresses 0x40, 0x41, 0x50, 0x51.
REQ-033 SHALL cover: 2D col, start 0x0, datasize 1, len0 1, len1 2, len2 0x20 -> addresses 0x0, 0x20, 0x40, 0x2, 0x22, 0x42.
REQ-034 SHALL cover: stream_ready_i held 0, linear len0 9 -> exactly 4 grants, then tx_ch_req_o low; after ready rises, all 10 elements arrive in order.
REQ-035 SHALL cover: gnt held 0 for 5 cycles -> tx_ch_addr_o stable and tx_ch_req_o high throughout; cmd_start_i during FETCH is ignored.
REQ-036 SHALL cover: start 0x7FFE, datasize 2, len0 1 -> addresses 0x7FFE, 0x0002; reset asserted mid-command -> all outputs 0 and next command correct.
